// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, redirect flushes,
// memory wait holds and halt draining, with saturating stall/flush event counters.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_RegWrite,
  input  logic [4:0]  ID_EX_WriteReg,
  input  logic        EX_MEM_MemRead,
  input  logic [4:0]  EX_MEM_WriteReg,
  input  logic        EX_MEM_MemAccess,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Jump,
  input  logic        ID_Halt,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_Flush,
  output logic        ID_EX_Bubble,
  output logic        Pipe_Hold,
  output logic        Halted,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

  state_t     state, state_nxt;
  logic [1:0] drain_cnt, drain_nxt;
  logic       stall_inc, flush_inc;
  logic       ex_match, mem_match;
  logic       hazard, branch_after_load, dhold, redirect;

  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign ex_match          = reg_match(ID_EX_WriteReg, IF_ID_Rs, IF_ID_Rt, ID_UsesRt);
  assign mem_match         = reg_match(EX_MEM_WriteReg, IF_ID_Rs, IF_ID_Rt, ID_UsesRt);
  assign branch_after_load = ID_Branch && ID_EX_MemRead && ex_match;
  assign hazard            = (ID_EX_MemRead && ex_match)
                           || (ID_Branch && ID_EX_RegWrite && ex_match)
                           || (ID_Branch && EX_MEM_MemRead && mem_match);
  assign dhold             = EX_MEM_MemAccess && !dmem_ready;
  assign redirect          = (ID_Branch && ID_BranchTaken) || ID_Jump;

  always_comb begin
    state_nxt    = state;
    drain_nxt    = drain_cnt;
    PCWrite      = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_Flush     = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Hold    = 1'b0;
    Halted       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (rst) begin
      IF_Flush     = 1'b1;
      ID_EX_Bubble = 1'b1;
      state_nxt    = RUN;
      drain_nxt    = 2'd0;
    end else if (state == HALTED) begin
      IF_Flush     = 1'b1;
      ID_EX_Bubble = 1'b1;
      Halted       = 1'b1;
    end else if (dhold) begin
      // Memory wait freezes everything, including a drain in progress
      Pipe_Hold = 1'b1;
      stall_inc = 1'b1;
    end else if (state == DRAIN) begin
      IF_Flush     = 1'b1;
      ID_EX_Bubble = 1'b1;
      drain_nxt    = drain_cnt - 2'd1;
      if (drain_cnt <= 2'd1) state_nxt = HALTED;
    end else if (state == STALL) begin
      ID_EX_Bubble = 1'b1;
      stall_inc    = 1'b1;
      state_nxt    = RUN;
    end else if (hazard) begin
      ID_EX_Bubble = 1'b1;
      stall_inc    = 1'b1;
      // A branch needing a loaded value waits one extra cycle in STALL
      if (branch_after_load) state_nxt = STALL;
    end else if (ID_Halt) begin
      IF_Flush     = 1'b1;
      ID_EX_Bubble = 1'b1;
      flush_inc    = 1'b1;
      drain_nxt    = 2'd3;
      state_nxt    = DRAIN;
    end else if (redirect) begin
      PCWrite   = 1'b1;
      IF_Flush  = 1'b1;
      flush_inc = 1'b1;
    end else if (!imem_ready) begin
      IF_Flush  = 1'b1;
      stall_inc = 1'b1;
    end else begin
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      drain_cnt  <= 2'd0;
      StallCount <= 16'd0;
      FlushCount <= 16'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (stall_inc) StallCount <= sat_inc(StallCount);
      if (flush_inc) FlushCount <= sat_inc(FlushCount);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: ID_EX_MemRead  in  1  load in EX.
REQ-004 SHALL: ID_EX_RegWrite  in  1  EX instruction writes a register.
REQ-005 SHALL: ID_EX_WriteReg  in  5  EX destination register, post-RegDst.
REQ-006 SHALL: EX_MEM_MemRead  in  1  load in MEM.
REQ-007 SHALL: EX_MEM_WriteReg  in  5  MEM destination register.
REQ-008 SHALL: EX_MEM_MemAccess  in  1  MEM stage reads or writes data memory.
REQ-009 SHALL: IF_ID_Rs  in  5  ID source rs.
REQ-010 SHALL: IF_ID_Rt  in  5  ID source rt.
REQ-011 SHALL: ID_UsesRt  in  1  ID instruction reads rt.
REQ-012 SHALL: ID_Branch  in  1  conditional branch decoded in ID.
REQ-013 SHALL: ID_BranchTaken  in  1  ID comparator result.
REQ-014 SHALL: ID_Jump  in  1  jump decoded in ID.
REQ-015 SHALL: ID_Halt  in  1  halt instruction decoded in ID.
REQ-016 SHALL: imem_ready  in  1  instruction fetch valid this cycle.
REQ-017 SHALL: dmem_ready  in  1  data access completes this cycle.
REQ-018 SHALL: PCWrite  out  1  PC update enable.
REQ-019 SHALL: IF_ID_Write  out  1  IF/ID load enable.
REQ-020 SHALL: IF_Flush  out  1  IF/ID clear (overrides IF_ID_Write).
REQ-021 SHALL: ID_EX_Bubble  out  1  zero ID/EX control fields.
REQ-022 SHALL: Pipe_Hold  out  1  hold ID/EX, EX/MEM, MEM/WB.
REQ-023 SHALL: Halted  out  1  pipeline drained after halt.
REQ-024 SHALL: StallCount  out  16  stall cycles, saturating.
REQ-025 SHALL: FlushCount  out  16  flush events, saturating.

Function
REQ-026 SHALL: states RUN, STALL, DRAIN, HALTED; 2-bit drain counter; control outputs combinational from state and inputs, state/counters registered.
REQ-027 SHALL: match(r) = (r!=0) && (r==IF_ID_Rs || (ID_UsesRt && r==IF_ID_Rt)).
REQ-028 SHALL: hazard = (ID_EX_MemRead && match(ID_EX_WriteReg)) || (ID_Branch && ID_EX_RegWrite && match(ID_EX_WriteReg)) || (ID_Branch && EX_MEM_MemRead && match(EX_MEM_WriteReg)).
REQ-029 SHALL: priority in RUN/STALL, first true wins: (1) dhold; (2) state STALL; (3) hazard; (4) ID_Halt; (5) redirect; (6) !imem_ready; (7) normal.
REQ-030 SHALL: dhold = EX_MEM_MemAccess && !dmem_ready: Pipe_Hold=1, PCWrite=IF_ID_Write=IF_Flush=ID_EX_Bubble=0; state and drain counter frozen, in every state except HALTED.
REQ-031 SHALL: stall (rules 2,3): PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; rule 2 returns to RUN; rule 3 enters STALL only if ID_Branch && ID_EX_MemRead && match(ID_EX_WriteReg) (branch-after-load: exactly 2 stall cycles), else stays RUN.
REQ-032 SHALL: halt: PCWrite=0, IF_Flush=1, ID_EX_Bubble=1, drain counter=3, next DRAIN.
REQ-033 SHALL: redirect = (ID_Branch && ID_BranchTaken) || ID_Jump: PCWrite=1, IF_Flush=1, one-cycle, no stall.
REQ-034 SHALL: !imem_ready: PCWrite=0, IF_Flush=1 (bubble into ID, older stages advance).
REQ-035 SHALL: normal: PCWrite=1, IF_ID_Write=1, all else 0.
REQ-036 SHALL: DRAIN/HALTED: PCWrite=0, IF_ID_Write=0, IF_Flush=1, ID_EX_Bubble=1; DRAIN decrements each non-dhold cycle, counter 1 -> HALTED; HALTED sets Halted=1, exits only on rst.
REQ-037 SHALL: StallCount +1 on cycles of rules 1,2,3,6; FlushCount +1 on rules 4,5; both saturate at 16'hFFFF.

Reset
REQ-038 SHALL: while rst=1: state RUN, drain counter 0, counters 0, PCWrite=0, IF_ID_Write=0, IF_Flush=1, ID_EX_Bubble=1, Pipe_Hold=0, Halted=0; rst mid-DRAIN/STALL/dhold aborts to RUN next cycle.

Verification
REQ-039 SHALL: load-use: ID_EX_MemRead=1, ID_EX_WriteReg=8, IF_ID_Rs=8 -> 1 cycle PCWrite=0, ID_EX_Bubble=1; StallCount=1.
REQ-040 SHALL: branch-after-load: ID_Branch=1, ID_EX_MemRead=1, ID_EX_WriteReg=9, IF_ID_Rt=9, ID_UsesRt=1 -> 2 stall cycles, then taken branch gives IF_Flush=1, FlushCount=1.
REQ-041 SHALL: WriteReg=0 matching Rs=0 with load in EX -> no stall, PCWrite=1.
REQ-042 SHALL: dhold 3 cycles during STALL -> Pipe_Hold=1 for 3 cycles, STALL resumes after, StallCount=+4.
REQ-043 SHALL: ID_Halt=1 -> IF_Flush=1, DRAIN 3 cycles, Halted=1 on 4th cycle onward; rst clears Halted next cycle.
REQ-044 SHALL: 65537 stall cycles -> StallCount=16'hFFFF, no wrap.
